display_digit_driver: RTL and testbench

Physical-side consumer of the scoreboard display bus (digit, one-hot position select, controller state). It latches each incoming 4-bit digit code into a per-position register and time-multiplexes the stored codes onto a 4-position common-anode/cathode 7-segment array. It also provides per-slot blanking against ghosting, a player-2 decimal-point indicator, and a sticky bus-error flag.

---
 rtl/display_digit_driver.sv | 120 ++++++++++++
 tb/tb_display_digit_driver.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/display_digit_driver.sv
// Scoreboard 7-segment driver: latches bus digits per position and time-multiplexes
// them onto a 4-position display with per-slot anti-ghost blanking.
module display_digit_driver #(
  parameter int SCAN_DIV       = 1024,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] digit_i,
  input  logic [3:0] segment_select_i,
  input  logic [2:0] state_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [3:0] an_o,
  output logic       sel_err_o,
  output logic [1:0] active_pos_o
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [3:0] AN_OFF  = {4{AN_ACTIVE_LOW}};

  logic [3:0][3:0]   pos_q, pos_d;
  logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]        active_pos_q, active_pos_d;
  logic              sel_err_q, sel_err_d;
  logic              p2_q, p2_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        an_q, an_d;
  logic              sel_onehot;
  logic              in_blank;
  logic [3:0]        cur_code;
  logic [6:0]        cur_pat;

  always_comb begin
    pos_d      = pos_q;
    sel_err_d  = sel_err_q;
    sel_onehot = (segment_select_i != 4'd0) &&
                 ((segment_select_i & (segment_select_i - 4'd1)) == 4'd0);
    if (sel_onehot) begin
      for (int i = 0; i < 4; i++)
        if (segment_select_i[i]) pos_d[i] = digit_i;
    end else if (segment_select_i != 4'd0) begin
      sel_err_d = 1'b1;
    end

    p2_d = (state_i == 3'd3) || (state_i == 3'd4) || (state_i == 3'd5);

    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d   = '0;
      active_pos_d = active_pos_q + 2'd1;
    end else begin
      scan_cnt_d   = scan_cnt_q + CNT_W'(1);
      active_pos_d = active_pos_q;
    end

    // Output stage reads only registered state, so a capture is seen one edge later
    cur_code = pos_q[active_pos_q];
    case (cur_code)
      4'h0:    cur_pat = 7'h3F;
      4'h1:    cur_pat = 7'h06;
      4'h2:    cur_pat = 7'h5B;
      4'h3:    cur_pat = 7'h4F;
      4'h4:    cur_pat = 7'h66;
      4'h5:    cur_pat = 7'h6D;
      4'h6:    cur_pat = 7'h7D;
      4'h7:    cur_pat = 7'h07;
      4'h8:    cur_pat = 7'h7F;
      4'h9:    cur_pat = 7'h6F;
      4'hF:    cur_pat = 7'h00;
      default: cur_pat = 7'h40;
    endcase

    in_blank = scan_cnt_q < BLANK_END;
    if (in_blank) begin
      seg_d = SEG_OFF;
      dp_d  = DP_OFF;
      an_d  = AN_OFF;
    end else begin
      seg_d = cur_pat ^ SEG_OFF;
      dp_d  = ((active_pos_q == 2'd0) && p2_q) ^ DP_OFF;
      an_d  = (4'b0001 << active_pos_q) ^ AN_OFF;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_q        <= {4{4'hF}};
      scan_cnt_q   <= '0;
      active_pos_q <= 2'd0;
      sel_err_q    <= 1'b0;
      p2_q         <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
    end else begin
      pos_q        <= pos_d;
      scan_cnt_q   <= scan_cnt_d;
      active_pos_q <= active_pos_d;
      sel_err_q    <= sel_err_d;
      p2_q         <= p2_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign an_o         = an_q;
  assign sel_err_o    = sel_err_q;
  assign active_pos_o = active_pos_q;

endmodule

// File: tb/tb_display_digit_driver.sv
// Directed bench for display_digit_driver with SCAN_DIV=8, BLANK_CYCLES=2, active-low outputs.
module tb_display_digit_driver;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] digit_i = 4'h0;
  logic [3:0] segment_select_i = 4'h0;
  logic [2:0] state_i = 3'd0;
  logic [6:0] seg_o;
  logic       dp_o;
  logic [3:0] an_o;
  logic       sel_err_o;
  logic [1:0] active_pos_o;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;                 // clock edges since last reset release
  logic [6:0] exp_pat[4];    // active-high pattern expected per position
  logic       exp_p2 = 1'b0;
  int act_cnt[4];

  display_digit_driver #(
    .SCAN_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .digit_i(digit_i),
    .segment_select_i(segment_select_i), .state_i(state_i),
    .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o),
    .sel_err_o(sel_err_o), .active_pos_o(active_pos_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp_v, n);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    n++;
  endtask

  // Scan expectation: outputs after edge n reflect the scan state before that edge
  task automatic sweep(input int cycles);
    int phase, pos;
    logic act;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    for (int c = 0; c < cycles; c++) begin
      tick();
      phase = (n - 1) % 8;
      pos   = ((n - 1) / 8) % 4;
      act   = (phase >= 2);
      e_an  = 4'b0001 << pos;
      e_an  = act ? ~e_an : 4'hF;
      e_seg = act ? ~exp_pat[pos] : 7'h7F;
      chk("an", {4'h0, an_o}, {4'h0, e_an});
      chk("seg", {1'b0, seg_o}, {1'b0, e_seg});
      chk("dp", {7'h0, dp_o}, {7'h0, !(act && pos == 0 && exp_p2)});
      chk("apos", {6'h0, active_pos_o}, 8'((n / 8) % 4));
      if (act && an_o != 4'hF) act_cnt[pos]++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin exp_pat[i] = 7'h00; act_cnt[i] = 0; end

    // 1: reset state and plain scan
    #12;
    chk("rst_an", {4'h0, an_o}, 8'h0F);
    chk("rst_seg", {1'b0, seg_o}, 8'h7F);
    chk("rst_dp", {7'h0, dp_o}, 8'h01);
    chk("rst_err", {7'h0, sel_err_o}, 8'h00);
    chk("rst_apos", {6'h0, active_pos_o}, 8'h00);
    #1 rst_i = 1'b0;
    n = 0;
    sweep(32);
    for (int i = 0; i < 4; i++) chk("act_cycles", 8'(act_cnt[i]), 8'd6);

    // 2: capture into pos0 and pos1
    digit_i = 4'h4; segment_select_i = 4'b0001; tick();
    digit_i = 4'h2; segment_select_i = 4'b0010; tick();
    segment_select_i = 4'b0000; tick();
    exp_pat[0] = 7'h66; exp_pat[1] = 7'h5B;
    sweep(32);

    // 3: player-2 decimal point
    state_i = 3'd4; tick(); tick();
    exp_p2 = 1'b1;
    sweep(32);
    state_i = 3'd1; tick(); tick();
    exp_p2 = 1'b0;
    sweep(32);

    // 4: non-one-hot select is ignored and sets the sticky error
    chk("err_pre", {7'h0, sel_err_o}, 8'h00);
    digit_i = 4'h7; segment_select_i = 4'b0011; tick();
    chk("err_set", {7'h0, sel_err_o}, 8'h01);
    digit_i = 4'h4; segment_select_i = 4'b0001; tick();
    chk("err_sticky", {7'h0, sel_err_o}, 8'h01);
    segment_select_i = 4'b0000;
    sweep(32);
    chk("err_hold", {7'h0, sel_err_o}, 8'h01);

    // 5: dash then blank in pos0
    digit_i = 4'hB; segment_select_i = 4'b0001; tick();
    segment_select_i = 4'b0000; tick();
    exp_pat[0] = 7'h40;
    sweep(32);
    digit_i = 4'hF; segment_select_i = 4'b0001; tick();
    segment_select_i = 4'b0000; tick();
    exp_pat[0] = 7'h00;
    sweep(32);

    // Mid-slot update to the active position shows on the following edge
    while (n % 32 != 3) tick();
    digit_i = 4'h9; segment_select_i = 4'b0001; tick();
    chk("mid_old", {1'b0, seg_o}, 8'h7F);
    segment_select_i = 4'b0000; tick();
    chk("mid_new", {1'b0, seg_o}, 8'h10);
    exp_pat[0] = 7'h6F;

    // 6: asynchronous reset while pos2 is displayed
    while (n % 32 != 20) tick();
    chk("pos2_an", {4'h0, an_o}, 8'h0B);
    #1 rst_i = 1'b1;
    #1;
    chk("arst_an", {4'h0, an_o}, 8'h0F);
    chk("arst_seg", {1'b0, seg_o}, 8'h7F);
    chk("arst_dp", {7'h0, dp_o}, 8'h01);
    chk("arst_err", {7'h0, sel_err_o}, 8'h00);
    chk("arst_apos", {6'h0, active_pos_o}, 8'h00);
    #2 rst_i = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) exp_pat[i] = 7'h00;
    sweep(32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
